pipelined_adder_nbit: RTL

Parametrised, pipelined unsigned adder with carry-in and carry-out (overflow). It supersedes the fixed 16-bit combinational adder in the datapath. The add is split into NUM_STAGES equal chunks, one chunk per pipeline stage, with the carry rippling stage to stage. A valid/ready handshake on both sides lets upstream producers and downstream consumers stream operands at one per cycle and apply backpressure.

---
 rtl/adder_pkg.sv | 12 +
 rtl/adder_chunk.sv | 17 +
 rtl/pipelined_adder_nbit.sv | 98 +++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// Shared helpers for the pipelined adder: configuration checks and chunk sizing.
package adder_pkg;

   function automatic bit chunking_ok(input int num_bits, input int num_stages);
      return (num_stages >= 1) && (num_bits >= 2) && ((num_bits % num_stages) == 0);
   endfunction

   function automatic int chunk_width(input int num_bits, input int num_stages);
      return num_bits / num_stages;
   endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational WIDTH-bit adder slice with carry in and carry out.
module adder_chunk #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             carry_in,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out
);

   logic [WIDTH:0] total;

   assign total            = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry_in};
   assign {carry_out, sum} = total;

endmodule

// File: rtl/pipelined_adder_nbit.sv
// Pipelined unsigned adder: one CHUNK-bit slice per stage, carry rippling through
// the stage registers, with a global stall driven by output backpressure.
module pipelined_adder_nbit
   import adder_pkg::*;
#(
   parameter int NUM_BITS   = 32,
   parameter int NUM_STAGES = 4
) (
   input  logic                clk,
   input  logic                n_rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [NUM_BITS-1:0] a,
   input  logic [NUM_BITS-1:0] b,
   input  logic                carry_in,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [NUM_BITS-1:0] sum,
   output logic                overflow
);

   localparam int CHUNK = chunk_width(NUM_BITS, NUM_STAGES);

   if (!chunking_ok(NUM_BITS, NUM_STAGES)) begin : g_bad_cfg
      $error("pipelined_adder_nbit: NUM_BITS must be >= 2 and a multiple of NUM_STAGES");
   end

   // Operands are shifted down by CHUNK each stage so every slice reads the low chunk.
   typedef struct packed {
      logic                valid;
      logic                carry;
      logic [NUM_BITS-1:0] sum_part;
      logic [NUM_BITS-1:0] a_rem;
      logic [NUM_BITS-1:0] b_rem;
   } stage_t;

   stage_t stage_q [NUM_STAGES];
   stage_t stage_d [NUM_STAGES];
   logic   stall;

   for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
      stage_t           src;
      stage_t           nxt;
      logic [CHUNK-1:0] chunk_sum;
      logic             chunk_carry;

      if (k == 0) begin : g_first
         assign src = '{valid: in_valid, carry: carry_in, sum_part: '0, a_rem: a, b_rem: b};
      end else begin : g_next
         assign src = stage_q[k-1];
      end

      adder_chunk #(.WIDTH(CHUNK)) u_chunk (
         .a         (src.a_rem[CHUNK-1:0]),
         .b         (src.b_rem[CHUNK-1:0]),
         .carry_in  (src.carry),
         .sum       (chunk_sum),
         .carry_out (chunk_carry)
      );

      always_comb begin
         nxt                            = src;
         nxt.carry                      = chunk_carry;
         nxt.sum_part[k*CHUNK +: CHUNK] = chunk_sum;
         nxt.a_rem                      = src.a_rem >> CHUNK;
         nxt.b_rem                      = src.b_rem >> CHUNK;
      end

      assign stage_d[k] = nxt;
   end

   assign stall    = out_valid && !out_ready;
   assign in_ready = !stall;

   // Bubbles advance the valid bit only, so the output keeps its last result.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         for (int k = 0; k < NUM_STAGES; k++) begin
            stage_q[k] <= '0;
         end
      end else if (!stall) begin
         for (int k = 0; k < NUM_STAGES; k++) begin
            stage_q[k].valid <= stage_d[k].valid;
            if (stage_d[k].valid) begin
               stage_q[k].carry    <= stage_d[k].carry;
               stage_q[k].sum_part <= stage_d[k].sum_part;
               stage_q[k].a_rem    <= stage_d[k].a_rem;
               stage_q[k].b_rem    <= stage_d[k].b_rem;
            end
         end
      end
   end

   assign out_valid = stage_q[NUM_STAGES-1].valid;
   assign sum       = stage_q[NUM_STAGES-1].sum_part;
   assign overflow  = stage_q[NUM_STAGES-1].carry;

endmodule
